fm_demodulator: RTL and testbench

Receive-side counterpart of the FM adapter. It accepts a stream of wrapped phase samples, for example from a CORDIC arctan stage after the I/Q mixer. For each sample it:
- forms the sample-to-sample phase difference modulo 2π,
- removes the carrier phase increment,
- scales the result by the carrier shift,
- saturates it and emits it as a signed frequency-deviation (velocity) stream.

It sits between the phase-extraction core and the downstream filter/DMA chain.

---
 rtl/fm_demodulator.sv | 89 ++++++++
 tb/tb_fm_demodulator.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fm_demodulator.sv
`default_nettype none
// ============================================================================
// fm_demodulator : wrapped-phase in, saturated signed frequency deviation out
// Revision 1.0
// ============================================================================
module fm_demodulator #(
  parameter int CARRIER_PINC_WIDTH = 32,
  parameter int AXIS_TDATA_WIDTH   = 32,
  parameter int OUTPUT_WIDTH       = 16
) (
  input  logic                          aclk,
  input  logic                          aresetn,
  input  logic                          fm_enable,
  input  logic [4:0]                    shift_carrier,
  input  logic [CARRIER_PINC_WIDTH-1:0] phase_carrier,
  input  logic [AXIS_TDATA_WIDTH-1:0]   S_AXIS_tdata,
  input  logic                          S_AXIS_tvalid,
  output logic                          S_AXIS_tready,
  output logic [OUTPUT_WIDTH-1:0]       M_AXIS_tdata,
  output logic                          M_AXIS_tvalid,
  input  logic                          M_AXIS_tready
);

  localparam int c_PW = CARRIER_PINC_WIDTH;
  localparam logic signed [c_PW-1:0] c_OUT_MAX =
    {{(c_PW-OUTPUT_WIDTH+1){1'b0}}, {(OUTPUT_WIDTH-1){1'b1}}};
  localparam logic signed [c_PW-1:0] c_OUT_MIN =
    {{(c_PW-OUTPUT_WIDTH+1){1'b1}}, {(OUTPUT_WIDTH-1){1'b0}}};

  logic                     r_primed;
  logic [c_PW-1:0]          r_prev;
  logic signed [c_PW-1:0]   r_dev;
  logic                     r_v1;
  logic                     r_m_valid;
  logic [OUTPUT_WIDTH-1:0]  r_m_data;

  logic                     w_ce;
  logic                     w_accept;
  logic [c_PW-1:0]          w_diff;
  logic [c_PW-1:0]          w_dev;
  logic signed [c_PW-1:0]   w_scaled;
  logic [OUTPUT_WIDTH-1:0]  w_sat;

  // Single enable for the whole pipeline: both stages move together or hold.
  assign w_ce     = !r_m_valid || M_AXIS_tready;
  assign w_accept = S_AXIS_tvalid && w_ce;

  assign w_diff   = S_AXIS_tdata - r_prev;
  assign w_dev    = w_diff - phase_carrier;
  assign w_scaled = r_dev >>> shift_carrier;

  always_comb begin
    w_sat = w_scaled[OUTPUT_WIDTH-1:0];
    if (w_scaled > c_OUT_MAX) begin
      w_sat = c_OUT_MAX[OUTPUT_WIDTH-1:0];
    end else if (w_scaled < c_OUT_MIN) begin
      w_sat = c_OUT_MIN[OUTPUT_WIDTH-1:0];
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_primed  <= 1'b0;
      r_prev    <= '0;
      r_dev     <= '0;
      r_v1      <= 1'b0;
      r_m_valid <= 1'b0;
      r_m_data  <= '0;
    end else if (w_ce) begin
      // History tracks every accepted sample, even with demodulation disabled.
      r_v1 <= w_accept && r_primed;
      if (w_accept) begin
        r_prev   <= S_AXIS_tdata;
        r_primed <= 1'b1;
        r_dev    <= w_dev;
      end
      r_m_valid <= r_v1;
      if (r_v1) begin
        r_m_data <= fm_enable ? w_sat : '0;
      end
    end
  end

  assign S_AXIS_tready = w_ce;
  assign M_AXIS_tvalid = r_m_valid;
  assign M_AXIS_tdata  = r_m_data;

endmodule
`default_nettype wire

// File: tb/tb_fm_demodulator.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// tb_fm_demodulator : directed + randomized bench with a behavioural model
// Revision 1.0
// ============================================================================
module tb_fm_demodulator;

  logic        aclk          = 1'b0;
  logic        aresetn       = 1'b1;
  logic        fm_enable     = 1'b1;
  logic [4:0]  shift_carrier = 5'd0;
  logic [31:0] phase_carrier = 32'd0;
  logic [31:0] S_AXIS_tdata  = 32'd0;
  logic        S_AXIS_tvalid = 1'b0;
  logic        S_AXIS_tready;
  logic [15:0] M_AXIS_tdata;
  logic        M_AXIS_tvalid;
  logic        M_AXIS_tready = 1'b1;

  int          checks = 0;
  int          errors = 0;
  logic [15:0] exp_q[$];
  logic [31:0] m_prev   = 32'd0;
  bit          m_primed = 1'b0;
  bit          rnd_done = 1'b0;

  fm_demodulator #(
    .CARRIER_PINC_WIDTH(32),
    .AXIS_TDATA_WIDTH  (32),
    .OUTPUT_WIDTH      (16)
  ) dut (
    .aclk         (aclk),
    .aresetn      (aresetn),
    .fm_enable    (fm_enable),
    .shift_carrier(shift_carrier),
    .phase_carrier(phase_carrier),
    .S_AXIS_tdata (S_AXIS_tdata),
    .S_AXIS_tvalid(S_AXIS_tvalid),
    .S_AXIS_tready(S_AXIS_tready),
    .M_AXIS_tdata (M_AXIS_tdata),
    .M_AXIS_tvalid(M_AXIS_tvalid),
    .M_AXIS_tready(M_AXIS_tready)
  );

  always #5 aclk = ~aclk;

  // Frequency deviation = floor(wrapped(ph - prev - carrier) / 2^sh), clamped.
  function automatic logic [15:0] model_out(input logic [31:0] ph, input logic [31:0] prev,
                                            input logic [31:0] car, input int sh, input bit en);
    logic [31:0] d;
    longint      dev;
    longint      p;
    longint      q;
    d   = ph - prev - car;
    dev = longint'($signed(d));
    p   = longint'(1) << sh;
    if (dev >= 0) q = dev / p;
    else          q = -((-dev + p - 1) / p);
    if (q > 32767)  q = 32767;
    if (q < -32768) q = -32768;
    return en ? q[15:0] : 16'd0;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_primed = 1'b0;
    exp_q.delete();
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge aclk);
    #1;
  endtask

  // Present one sample; it is accepted on the first rising edge with tready high.
  task automatic send(input logic [31:0] ph);
    int g;
    g = 0;
    S_AXIS_tdata  = ph;
    S_AXIS_tvalid = 1'b1;
    #1;
    while (!S_AXIS_tready && g < 200) begin
      @(negedge aclk);
      #2;
      g++;
    end
    if (g >= 200) begin
      check("send_timeout", 32'd1, 32'd0);
    end else begin
      if (m_primed)
        exp_q.push_back(model_out(ph, m_prev, phase_carrier, int'(shift_carrier), fm_enable));
      m_prev   = ph;
      m_primed = 1'b1;
    end
    @(negedge aclk);
    #1;
    S_AXIS_tvalid = 1'b0;
  endtask

  // Send into an empty pipeline and check the one-edge stage-2 latency.
  task automatic send_lat(input logic [31:0] ph);
    send(ph);
    check("lat_early_valid", {31'd0, M_AXIS_tvalid}, 32'd0);
    @(negedge aclk);
    #2;
    check("lat_valid", {31'd0, M_AXIS_tvalid}, 32'd1);
  endtask

  // Output monitor: scoreboard pops on every transfer, stalls must hold data.
  initial begin
    logic [15:0] held;
    logic [15:0] e;
    bit          stalled;
    stalled = 1'b0;
    held    = '0;
    forever begin
      @(negedge aclk);
      #3;
      if (!aresetn) begin
        stalled = 1'b0;
      end else begin
        if (stalled) begin
          check("stall_hold_data", {16'd0, M_AXIS_tdata}, {16'd0, held});
          check("stall_hold_valid", {31'd0, M_AXIS_tvalid}, 32'd1);
        end
        if (M_AXIS_tvalid && M_AXIS_tready) begin
          checks++;
          assert (exp_q.size() != 0) else begin
            errors++;
            $error("FAIL unexpected_output obs=%0h exp=none", M_AXIS_tdata);
          end
          if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            checks++;
            assert (M_AXIS_tdata === e) else begin
              errors++;
              $error("FAIL out_data obs=%0d exp=%0d", $signed(M_AXIS_tdata), $signed(e));
            end
          end
          stalled = 1'b0;
        end else if (M_AXIS_tvalid) begin
          check("stall_s_tready", {31'd0, S_AXIS_tready}, 32'd0);
          stalled = 1'b1;
          held    = M_AXIS_tdata;
        end else begin
          stalled = 1'b0;
        end
      end
    end
  end

  initial begin
    int g;
    logic [31:0] car;

    #2 aresetn = 1'b0;
    #10;
    check("rst_m_tvalid", {31'd0, M_AXIS_tvalid}, 32'd0);
    check("rst_m_tdata", {16'd0, M_AXIS_tdata}, 32'd0);
    check("rst_s_tready", {31'd0, S_AXIS_tready}, 32'd1);
    @(negedge aclk);
    #1 aresetn = 1'b1;
    model_reset();
    idle(1);

    // Basic: first sample primes only, then 16, 32, 0
    phase_carrier = 32'h1000_0000;
    shift_carrier = 5'd0;
    send(32'h0000_0000);
    @(negedge aclk);
    #2;
    check("prime_no_output", {31'd0, M_AXIS_tvalid}, 32'd0);
    send_lat(32'h1000_0010);
    send_lat(32'h2000_0030);
    send_lat(32'h3000_0030);
    idle(2);

    // Wrap-around of the phase difference, then negative saturation
    send(32'hF000_0000);
    send(32'h0000_0010);
    idle(2);
    phase_carrier = 32'd0;
    send(32'h0000_0000);
    send(32'hF000_0000);
    idle(2);

    // Shift and saturation
    shift_carrier = 5'd4;
    send(32'h0000_0000);
    send(32'h0001_0000);
    idle(2);
    shift_carrier = 5'd0;
    send(32'h0002_0000);
    send(32'h0001_0000);
    idle(2);
    shift_carrier = 5'd31;
    send(32'h0000_FFFB);
    idle(2);

    // fm_enable low forces zero outputs while history keeps tracking
    phase_carrier = 32'h0010_0000;
    shift_carrier = 5'd8;
    fm_enable     = 1'b0;
    send(m_prev + 32'h0010_0300);
    send(m_prev + 32'h0010_0200);
    idle(2);
    fm_enable = 1'b1;
    send(m_prev + 32'h0010_0500);
    idle(2);

    // Backpressure: tready low for 3 cycles in the middle of a 6-sample burst
    phase_carrier = 32'h0100_0000;
    shift_carrier = 5'd4;
    fork
      begin
        repeat (3) @(negedge aclk);
        #1 M_AXIS_tready = 1'b0;
        repeat (3) @(negedge aclk);
        #1 M_AXIS_tready = 1'b1;
      end
      begin
        for (int i = 0; i < 6; i++)
          send(m_prev + 32'h0100_0000 + ($urandom & 32'h000F_FFFF) - 32'h0008_0000);
      end
    join
    idle(3);
    check("bp_all_drained", exp_q.size(), 32'd0);

    // Randomized stream with random backpressure
    car           = $urandom;
    phase_carrier = car;
    shift_carrier = 5'($urandom_range(0, 12));
    rnd_done      = 1'b0;
    fork
      begin
        while (!rnd_done) begin
          @(negedge aclk);
          #1 M_AXIS_tready = 1'($urandom_range(0, 1));
        end
      end
      begin
        for (int i = 0; i < 24; i++) begin
          if (i % 6 == 5) send($urandom);
          else send(m_prev + car + ($urandom & 32'h003F_FFFF) - 32'h0020_0000);
        end
        rnd_done = 1'b1;
      end
    join
    M_AXIS_tready = 1'b1;
    idle(3);

    // Reset mid-stream while an output is stalled at the interface
    phase_carrier = 32'h0000_1000;
    shift_carrier = 5'd0;
    send(m_prev + 32'h0000_1010);
    send(m_prev + 32'h0000_1020);
    M_AXIS_tready = 1'b0;
    @(negedge aclk);
    #2;
    check("rst_pre_valid", {31'd0, M_AXIS_tvalid}, 32'd1);
    aresetn = 1'b0;
    model_reset();
    #1;
    check("rst_async_tvalid", {31'd0, M_AXIS_tvalid}, 32'd0);
    @(negedge aclk);
    #1;
    aresetn       = 1'b1;
    M_AXIS_tready = 1'b1;
    send(32'h4000_0000);
    @(negedge aclk);
    #2;
    check("rst_reprime_no_output", {31'd0, M_AXIS_tvalid}, 32'd0);
    send_lat(32'h4000_1123);

    g = 0;
    while (exp_q.size() != 0 && g < 100) begin
      @(negedge aclk);
      g++;
    end
    idle(2);
    check("final_drained", exp_q.size(), 32'd0);
    check("final_idle_tvalid", {31'd0, M_AXIS_tvalid}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
